// File: rtl/branch_resolver.sv
// Pipeline-side branch predictor client: BTB lookup, next-PC select, in-flight
// prediction FIFO, and resolution-time training, flush and redirect.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 4
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            fetch_en,
  input  logic [31:0]     fetch_pc,
  input  logic            fetch_is_br,
  output logic [31:0]     next_pc,
  output logic            stall,
  input  logic            ex_resolve,
  input  logic            ex_taken,
  input  logic [31:0]     ex_target,
  output logic            flush,
  output logic [31:0]     redirect_pc,
  output logic [IDXW-1:0] index_I,
  input  logic            predict,
  input  logic [31:0]     br_target_O,
  input  logic [IDXW-1:0] index_O,
  output logic            br,
  output logic [IDXW-1:0] index_update,
  output logic            br_taken,
  output logic [31:0]     br_target_I,
  output logic [15:0]     br_count,
  output logic [15:0]     mis_count,
  output logic            err_underflow
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = PTRW + 1;

  logic [IDXW-1:0] ent_index  [DEPTH];
  logic            ent_pred   [DEPTH];
  logic [31:0]     ent_target [DEPTH];
  logic [31:0]     ent_pc4    [DEPTH];

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        mispredict;
  logic [31:0] correct_pc;

  assign index_I = fetch_pc[IDXW+1:2];
  assign next_pc = (fetch_is_br && predict) ? br_target_O : fetch_pc + 32'd4;

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);
  assign stall = full && fetch_is_br;

  // The flush cycle itself accepts no pushes: that fetch is on the squashed path.
  assign push = fetch_en && fetch_is_br && !full && !flush;
  assign pop  = ex_resolve && !empty;

  assign mispredict = (ent_pred[rd_ptr] != ex_taken) ||
                      (ex_taken && (ent_target[rd_ptr] != ex_target));
  assign correct_pc = ex_taken ? ex_target : ent_pc4[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      ent_index[wr_ptr]  <= index_O;
      ent_pred[wr_ptr]   <= predict;
      ent_target[wr_ptr] <= br_target_O;
      ent_pc4[wr_ptr]    <= fetch_pc + 32'd4;
    end
  end

  // A mispredict squashes every younger entry, including one pushed on the same edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (pop && mispredict) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br           <= 1'b0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
      index_update <= '0;
      br_taken     <= 1'b0;
      br_target_I  <= '0;
    end else begin
      br          <= pop;
      flush       <= pop && mispredict;
      redirect_pc <= (pop && mispredict) ? correct_pc : 32'd0;
      if (pop) begin
        index_update <= ent_index[rd_ptr];
        br_taken     <= ex_taken;
        br_target_I  <= ex_target;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_count      <= '0;
      mis_count     <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pop && (br_count != 16'hFFFF)) br_count <= br_count + 16'd1;
      if (pop && mispredict && (mis_count != 16'hFFFF)) mis_count <= mis_count + 16'd1;
      if (ex_resolve && empty) err_underflow <= 1'b1;
    end
  end

endmodule
